instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 239 +++++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// ============================================================================
// Module   : instruction_encoder
// Purpose  : Encodes RV32I operand bundles and streams them out LSB-byte first.
//            Define ENCODER_RANGE_CHECK_EN to reject out-of-range immediates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  operation,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] immediate,
    input  logic        input_valid,
    output logic        input_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        error,
    output logic [15:0] instruction_count
);

    localparam logic [5:0] c_OP_LUI   = 6'd0;
    localparam logic [5:0] c_OP_AUIPC = 6'd1;
    localparam logic [5:0] c_OP_JAL   = 6'd2;
    localparam logic [5:0] c_OP_JALR  = 6'd3;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_BNE   = 6'd5;
    localparam logic [5:0] c_OP_BLT   = 6'd6;
    localparam logic [5:0] c_OP_BGE   = 6'd7;
    localparam logic [5:0] c_OP_BLTU  = 6'd8;
    localparam logic [5:0] c_OP_BGEU  = 6'd9;
    localparam logic [5:0] c_OP_LB    = 6'd10;
    localparam logic [5:0] c_OP_LH    = 6'd11;
    localparam logic [5:0] c_OP_LW    = 6'd12;
    localparam logic [5:0] c_OP_LBU   = 6'd13;
    localparam logic [5:0] c_OP_LHU   = 6'd14;
    localparam logic [5:0] c_OP_SB    = 6'd15;
    localparam logic [5:0] c_OP_SH    = 6'd16;
    localparam logic [5:0] c_OP_SW    = 6'd17;
    localparam logic [5:0] c_OP_ADDI  = 6'd18;
    localparam logic [5:0] c_OP_SLTI  = 6'd19;
    localparam logic [5:0] c_OP_SLTIU = 6'd20;
    localparam logic [5:0] c_OP_XORI  = 6'd21;
    localparam logic [5:0] c_OP_ORI   = 6'd22;
    localparam logic [5:0] c_OP_ANDI  = 6'd23;
    localparam logic [5:0] c_OP_SLLI  = 6'd24;
    localparam logic [5:0] c_OP_SRLI  = 6'd25;
    localparam logic [5:0] c_OP_SRAI  = 6'd26;
    localparam logic [5:0] c_OP_ADD   = 6'd27;
    localparam logic [5:0] c_OP_SUB   = 6'd28;
    localparam logic [5:0] c_OP_SLL   = 6'd29;
    localparam logic [5:0] c_OP_SLT   = 6'd30;
    localparam logic [5:0] c_OP_SLTU  = 6'd31;
    localparam logic [5:0] c_OP_XOR   = 6'd32;
    localparam logic [5:0] c_OP_SRL   = 6'd33;
    localparam logic [5:0] c_OP_SRA   = 6'd34;
    localparam logic [5:0] c_OP_OR    = 6'd35;
    localparam logic [5:0] c_OP_AND   = 6'd36;

    localparam logic [2:0] c_FMT_NONE = 3'd0;
    localparam logic [2:0] c_FMT_R    = 3'd1;
    localparam logic [2:0] c_FMT_I    = 3'd2;
    localparam logic [2:0] c_FMT_SH   = 3'd3;
    localparam logic [2:0] c_FMT_S    = 3'd4;
    localparam logic [2:0] c_FMT_B    = 3'd5;
    localparam logic [2:0] c_FMT_U    = 3'd6;
    localparam logic [2:0] c_FMT_J    = 3'd7;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [6:0] c_F7_ALT = 7'b0100000;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_index;
    logic [31:0] r_holding;
    logic        r_error;
    logic [15:0] r_count;

    logic [2:0]  w_fmt;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_encoded;
    logic        w_in_range;
    logic        w_reject;

    always_comb begin
        w_fmt    = c_FMT_NONE;
        w_opcode = 7'd0;
        w_funct3 = 3'd0;
        w_funct7 = 7'd0;
        case (operation)
            c_OP_LUI:   begin w_fmt = c_FMT_U;  w_opcode = c_OPC_LUI;                      end
            c_OP_AUIPC: begin w_fmt = c_FMT_U;  w_opcode = c_OPC_AUIPC;                    end
            c_OP_JAL:   begin w_fmt = c_FMT_J;  w_opcode = c_OPC_JAL;                      end
            c_OP_JALR:  begin w_fmt = c_FMT_I;  w_opcode = c_OPC_JALR;                     end
            c_OP_BEQ:   begin w_fmt = c_FMT_B;  w_opcode = c_OPC_BRANCH; w_funct3 = 3'b000; end
            c_OP_BNE:   begin w_fmt = c_FMT_B;  w_opcode = c_OPC_BRANCH; w_funct3 = 3'b001; end
            c_OP_BLT:   begin w_fmt = c_FMT_B;  w_opcode = c_OPC_BRANCH; w_funct3 = 3'b100; end
            c_OP_BGE:   begin w_fmt = c_FMT_B;  w_opcode = c_OPC_BRANCH; w_funct3 = 3'b101; end
            c_OP_BLTU:  begin w_fmt = c_FMT_B;  w_opcode = c_OPC_BRANCH; w_funct3 = 3'b110; end
            c_OP_BGEU:  begin w_fmt = c_FMT_B;  w_opcode = c_OPC_BRANCH; w_funct3 = 3'b111; end
            c_OP_LB:    begin w_fmt = c_FMT_I;  w_opcode = c_OPC_LOAD;   w_funct3 = 3'b000; end
            c_OP_LH:    begin w_fmt = c_FMT_I;  w_opcode = c_OPC_LOAD;   w_funct3 = 3'b001; end
            c_OP_LW:    begin w_fmt = c_FMT_I;  w_opcode = c_OPC_LOAD;   w_funct3 = 3'b010; end
            c_OP_LBU:   begin w_fmt = c_FMT_I;  w_opcode = c_OPC_LOAD;   w_funct3 = 3'b100; end
            c_OP_LHU:   begin w_fmt = c_FMT_I;  w_opcode = c_OPC_LOAD;   w_funct3 = 3'b101; end
            c_OP_SB:    begin w_fmt = c_FMT_S;  w_opcode = c_OPC_STORE;  w_funct3 = 3'b000; end
            c_OP_SH:    begin w_fmt = c_FMT_S;  w_opcode = c_OPC_STORE;  w_funct3 = 3'b001; end
            c_OP_SW:    begin w_fmt = c_FMT_S;  w_opcode = c_OPC_STORE;  w_funct3 = 3'b010; end
            c_OP_ADDI:  begin w_fmt = c_FMT_I;  w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b000; end
            c_OP_SLTI:  begin w_fmt = c_FMT_I;  w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b010; end
            c_OP_SLTIU: begin w_fmt = c_FMT_I;  w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b011; end
            c_OP_XORI:  begin w_fmt = c_FMT_I;  w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b100; end
            c_OP_ORI:   begin w_fmt = c_FMT_I;  w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b110; end
            c_OP_ANDI:  begin w_fmt = c_FMT_I;  w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b111; end
            c_OP_SLLI:  begin w_fmt = c_FMT_SH; w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b001; end
            c_OP_SRLI:  begin w_fmt = c_FMT_SH; w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b101; end
            c_OP_SRAI:  begin w_fmt = c_FMT_SH; w_opcode = c_OPC_OPIMM;  w_funct3 = 3'b101; w_funct7 = c_F7_ALT; end
            c_OP_ADD:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b000; end
            c_OP_SUB:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b000; w_funct7 = c_F7_ALT; end
            c_OP_SLL:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b001; end
            c_OP_SLT:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b010; end
            c_OP_SLTU:  begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b011; end
            c_OP_XOR:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b100; end
            c_OP_SRL:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b101; end
            c_OP_SRA:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b101; w_funct7 = c_F7_ALT; end
            c_OP_OR:    begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b110; end
            c_OP_AND:   begin w_fmt = c_FMT_R;  w_opcode = c_OPC_OP;     w_funct3 = 3'b111; end
            default:    w_fmt = c_FMT_NONE;
        endcase
    end

    // Register fields a format does not carry are left out, so they encode as zero.
    always_comb begin
        w_encoded = 32'd0;
        case (w_fmt)
            c_FMT_R:  w_encoded = {w_funct7, rs2, rs1, w_funct3, rd, w_opcode};
            c_FMT_I:  w_encoded = {immediate[11:0], rs1, w_funct3, rd, w_opcode};
            c_FMT_SH: w_encoded = {w_funct7, immediate[4:0], rs1, w_funct3, rd, w_opcode};
            c_FMT_S:  w_encoded = {immediate[11:5], rs2, rs1, w_funct3, immediate[4:0], w_opcode};
            c_FMT_B:  w_encoded = {immediate[12], immediate[10:5], rs2, rs1, w_funct3,
                                   immediate[4:1], immediate[11], w_opcode};
            c_FMT_U:  w_encoded = {immediate[31:12], rd, w_opcode};
            c_FMT_J:  w_encoded = {immediate[20], immediate[10:1], immediate[11],
                                   immediate[19:12], rd, w_opcode};
            default:  w_encoded = 32'd0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    always_comb begin
        w_in_range = 1'b1;
        case (w_fmt)
            c_FMT_I,
            c_FMT_S:  w_in_range = (immediate[31:11] == {21{immediate[11]}});
            c_FMT_SH: w_in_range = (immediate[31:5] == 27'd0);
            c_FMT_B:  w_in_range = (immediate[31:12] == {20{immediate[12]}}) && !immediate[0];
            c_FMT_U:  w_in_range = (immediate[11:0] == 12'd0);
            c_FMT_J:  w_in_range = (immediate[31:20] == {12{immediate[20]}}) && !immediate[0];
            default:  w_in_range = 1'b1;
        endcase
    end
`else
    assign w_in_range = 1'b1;
`endif

    assign w_reject = (w_fmt == c_FMT_NONE) || !w_in_range;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_index   <= 2'd0;
            r_holding <= 32'd0;
            r_error   <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (input_valid) begin
                        if (w_reject) begin
                            r_error <= 1'b1;
                        end else begin
                            r_holding <= w_encoded;
                            r_index   <= 2'd0;
                            r_state   <= c_SEND;
                        end
                    end
                end
                c_SEND: begin
                    if (byte_ready) begin
                        r_index <= r_index + 2'd1;
                        if (r_index == 2'd3) begin
                            r_state <= c_IDLE;
                            r_count <= r_count + 16'd1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_data = 8'd0;
        if (r_state == c_SEND) begin
            case (r_index)
                2'd0:    byte_data = r_holding[7:0];
                2'd1:    byte_data = r_holding[15:8];
                2'd2:    byte_data = r_holding[23:16];
                default: byte_data = r_holding[31:24];
            endcase
        end
    end

    assign input_ready       = (r_state == c_IDLE);
    assign byte_valid        = (r_state == c_SEND);
    assign error             = r_error;
    assign instruction_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ============================================================================
// Module   : tb_instruction_encoder
// Purpose  : Table-driven, scoreboarded bench for instruction_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_encoder;

    localparam logic [5:0] c_OP_LUI     = 6'd0;
    localparam logic [5:0] c_OP_AUIPC   = 6'd1;
    localparam logic [5:0] c_OP_JAL     = 6'd2;
    localparam logic [5:0] c_OP_JALR    = 6'd3;
    localparam logic [5:0] c_OP_BEQ     = 6'd4;
    localparam logic [5:0] c_OP_BNE     = 6'd5;
    localparam logic [5:0] c_OP_LW      = 6'd12;
    localparam logic [5:0] c_OP_SW      = 6'd17;
    localparam logic [5:0] c_OP_ADDI    = 6'd18;
    localparam logic [5:0] c_OP_SRAI    = 6'd26;
    localparam logic [5:0] c_OP_ADD     = 6'd27;
    localparam logic [5:0] c_OP_SUB     = 6'd28;
    localparam logic [5:0] c_OP_OR      = 6'd35;
    localparam logic [5:0] c_OP_INVALID = 6'd37;
    localparam int         c_NVEC       = 14;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
        bit          err;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  operation;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] immediate;
    logic        input_valid;
    logic        input_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        error;
    logic [15:0] instruction_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          model_count = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[c_NVEC];

    always #5 clock = ~clock;

    instruction_encoder dut (
        .clock             (clock),
        .reset             (reset),
        .operation         (operation),
        .rd                (rd),
        .rs1               (rs1),
        .rs2               (rs2),
        .immediate         (immediate),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .byte_data         (byte_data),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .error             (error),
        .instruction_count (instruction_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Waits for the encoder to return to IDLE, then checks the emitted count.
    task automatic finish_wait(input string name);
        int guard = 0;
        while (!input_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check({name, " done"}, {31'd0, input_ready}, 32'd1);
        model_count++;
        check({name, " count"}, {16'd0, instruction_count}, model_count);
    endtask

    task automatic send(input vec_t v, input bit wait_done, input string name);
        int guard = 0;
        @(negedge clock);
        while (!input_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check({name, " ready"}, {31'd0, input_ready}, 32'd1);
        operation   = v.op;
        rd          = v.rd;
        rs1         = v.rs1;
        rs2         = v.rs2;
        immediate   = v.imm;
        input_valid = 1'b1;
        if (!v.err) exp_q.push_back(v.word);
        @(posedge clock);
        #1 input_valid = 1'b0;
        @(negedge clock);
        check({name, " error"}, {31'd0, error}, {31'd0, v.err});
        check({name, " byte_valid"}, {31'd0, byte_valid}, {31'd0, !v.err});
        if (v.err) begin
            check({name, " ready after err"}, {31'd0, input_ready}, 32'd1);
            @(negedge clock);
            check({name, " error pulse end"}, {31'd0, error}, 32'd0);
            check({name, " no bytes"}, {31'd0, byte_valid}, 32'd0);
            check({name, " count kept"}, {16'd0, instruction_count}, model_count);
        end else if (wait_done) begin
            finish_wait(name);
        end
    endtask

    // Byte collector: assembles LSB-first words, checks stall stability.
    initial begin
        int          nbytes = 0;
        logic [31:0] acc = 32'd0;
        logic [7:0]  prev = 8'd0;
        bit          stalled = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                nbytes  = 0;
                stalled = 1'b0;
            end else begin
                if (stalled && byte_valid) check("stall hold", {24'd0, byte_data}, {24'd0, prev});
                if (byte_valid && byte_ready) begin
                    acc = {byte_data, acc[31:8]};
                    nbytes++;
                    if (nbytes == 4) begin
                        nbytes = 0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected word: got %h, expected none", acc);
                        end else begin
                            check("word", acc, exp_q.pop_front());
                        end
                    end
                end
                stalled = byte_valid && !byte_ready;
                prev    = byte_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{c_OP_ADDI,    5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093, 1'b0};
        vecs[1]  = '{c_OP_ADD,     5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b0};
        vecs[2]  = '{c_OP_SUB,     5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0};
        vecs[3]  = '{c_OP_JAL,     5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF, 1'b0};
        vecs[4]  = '{c_OP_SW,      5'd0, 5'd2, 5'd5, 32'd8,          32'h00512423, 1'b0};
        vecs[5]  = '{c_OP_SRAI,    5'd1, 5'd1, 5'd0, 32'd3,          32'h4030D093, 1'b0};
        vecs[6]  = '{c_OP_LW,      5'd6, 5'd2, 5'd0, 32'hFFFFFFFC,   32'hFFC12303, 1'b0};
        vecs[7]  = '{c_OP_AUIPC,   5'd1, 5'd0, 5'd0, 32'h00001000,   32'h00001097, 1'b0};
        vecs[8]  = '{c_OP_JALR,    5'd0, 5'd1, 5'd0, 32'd0,          32'h00008067, 1'b0};
        vecs[9]  = '{c_OP_OR,      5'd4, 5'd5, 5'd6, 32'd0,          32'h0062E233, 1'b0};
        vecs[10] = '{c_OP_BNE,     5'd0, 5'd3, 5'd0, 32'd16,         32'h00019863, 1'b0};
`ifdef ENCODER_RANGE_CHECK_EN
        vecs[11] = '{c_OP_ADDI,    5'd1, 5'd0, 5'd0, 32'd2048,       32'h00000000, 1'b1};
`else
        vecs[11] = '{c_OP_ADDI,    5'd1, 5'd0, 5'd0, 32'd2048,       32'h80000093, 1'b0};
`endif
        vecs[12] = '{c_OP_INVALID, 5'd1, 5'd2, 5'd3, 32'd1,          32'h00000000, 1'b1};
        vecs[13] = '{6'd63,        5'd1, 5'd2, 5'd3, 32'd1,          32'h00000000, 1'b1};

        reset       = 1'b1;
        input_valid = 1'b0;
        byte_ready  = 1'b1;
        operation   = c_OP_INVALID;
        rd          = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
        immediate   = 32'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset input_ready", {31'd0, input_ready}, 32'd1);
        check("reset byte_valid", {31'd0, byte_valid}, 32'd0);
        check("reset byte_data", {24'd0, byte_data}, 32'd0);
        check("reset error", {31'd0, error}, 32'd0);
        check("reset count", {16'd0, instruction_count}, 32'd0);

        for (int i = 0; i < c_NVEC; i++) begin
            send(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // beq with a three-cycle sink stall on byte 1
        v = '{c_OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
        send(v, 1'b0, "beq stall");
        @(posedge clock);
        #1 byte_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 byte_ready = 1'b1;
        finish_wait("beq stall");

        // lui abandoned by reset while byte index 2 is presented
        v = '{c_OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0};
        send(v, 1'b0, "lui reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clock);
        #1 reset = 1'b0;
        model_count = 0;
        @(negedge clock);
        check("mid reset input_ready", {31'd0, input_ready}, 32'd1);
        check("mid reset byte_valid", {31'd0, byte_valid}, 32'd0);
        check("mid reset count", {16'd0, instruction_count}, 32'd0);
        send(v, 1'b1, "lui resend");

        repeat (3) @(negedge clock);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
